// File: rtl/spi_word_rx_pkg.sv
// Shared types and helpers for the SPI word receiver.
package spi_rx_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   // Default word width and its counter width; the top re-derives CNT_W for its own WORD_W.
   localparam int DEF_WORD_W = 32;
   localparam int CNT_W      = $clog2(DEF_WORD_W);

   function automatic logic cs_active(input logic raw, input bit active_low);
      return active_low ? ~raw : raw;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, with rise/fall detection on the synced level.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d_async};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign q    = sync[SYNC_STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 target: oversamples sck/cs/mosi, assembles MSB-first words and
// presents them on a single-entry valid/ready buffer with overrun/frame flags.
module spi_word_rx
   import spi_rx_pkg::*;
#(
   parameter int WORD_W        = 32,
   parameter int SYNC_STAGES   = 2,
   parameter bit CS_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              frame_err,
   input  logic              clr_err
);

   localparam int          CW      = $clog2(WORD_W);
   localparam logic [CW-1:0] LAST  = CW'(WORD_W - 1);
   localparam logic        CS_IDLE = CS_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic sck_q_unused, sck_rise, sck_fall_unused;
   logic cs_q, cs_rise, cs_fall;
   logic mosi, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .d_async(spi_sck),
      .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall_unused)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs (
      .clk(clk), .rst(rst), .d_async(spi_cs),
      .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .d_async(spi_mosi),
      .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   // Any cs edge, qualified by the level it landed on, is a start or a stop.
   logic cs_edge, cs_start, cs_stop;
   assign cs_edge  = cs_rise | cs_fall;
   assign cs_start = cs_edge &  cs_active(cs_q, CS_ACTIVE_LOW);
   assign cs_stop  = cs_edge & ~cs_active(cs_q, CS_ACTIVE_LOW);

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [WORD_W-1:0] shreg, shreg_nx, word_nx;
   logic              done, ferr_nx;

   assign word_nx = {shreg[WORD_W-2:0], mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         shreg     <= shreg_nx;
         frame_err <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      done     = 1'b0;
      ferr_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_start) begin
               state_nx = SHIFT;
               cnt_nx   = '0;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               shreg_nx = word_nx;
               if (cnt == LAST) begin
                  done   = 1'b1;
                  cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            // A final bit landing with the cs stop completes the word first, so no error.
            if (cs_stop) begin
               state_nx = IDLE;
               ferr_nx  = (cnt_nx != '0);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= word_nx;
               rx_valid <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         // Set beats clear when both land in the same cycle.
         if (done && rx_valid && !rx_ready) overrun <= 1'b1;
         else if (clr_err)                  overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: a word-queue model checked on every accept,
// plus per-cycle hold/pulse checks and literal expectations per scenario.
module tb_spi_word_rx;

   logic        clk = 1'b0;
   logic        rst, spi_sck, spi_cs, spi_mosi, rx_ready, clr_err;
   logic [31:0] rx_data;
   logic        rx_valid, overrun, frame_err;

   int checks = 0, failures = 0;
   int acc_cnt = 0, ferr_cnt = 0;
   logic [31:0] exp_q[$];
   logic        prev_hold = 1'b0, prev_ferr = 1'b0, valid_dropped = 1'b0;
   logic [31:0] prev_data = '0;

   always #2 clk = ~clk;

   spi_word_rx #(.WORD_W(32), .SYNC_STAGES(2), .CS_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every accepted word must be the model's next word; a
   // stalled buffer must hold; frame_err must never be wider than one clk.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
         prev_ferr = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", {31'b0, rx_valid}, 32'd1);
            chk("hold_data", rx_data, prev_data);
         end
         if (rx_valid && rx_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL accept_unexpected actual=%h expected=none @%0t", rx_data, $time);
            end else begin
               chk("accept_data", rx_data, exp_q.pop_front());
            end
         end
         chk("ferr_width", {31'b0, frame_err & prev_ferr}, 32'd0);
         if (frame_err) ferr_cnt++;
         if (!rx_valid) valid_dropped = 1'b1;
         prev_hold = rx_valid && !rx_ready;
         prev_data = rx_data;
         prev_ferr = frame_err;
      end
   end

   // Leaves time 1 unit after a rising clk edge, clear of both edges.
   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic cs_on();
      align();
      spi_cs = 1'b0;
      #20;
   endtask

   task automatic cs_off();
      #20;
      spi_cs = 1'b1;
      #40;
   endtask

   // Sends the top n bits of w; optionally pulses rx_ready for exactly the
   // clk edge at which the final bit completes (3rd edge after the sck rise).
   task automatic send_bits(input logic [31:0] w, input int n, input bit pulse_last);
      for (int i = 0; i < n; i++) begin
         spi_mosi = w[31-i];
         #20;
         spi_sck = 1'b1;
         if (pulse_last && i == n - 1) begin
            #8  rx_ready = 1'b1;
            #4  rx_ready = 1'b0;
            #8;
         end else begin
            #20;
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      rx_ready = 1'b1;
      while ((exp_q.size() != 0 || rx_valid) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc0, ferr0;
      rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
      rx_ready = 1'b0; clr_err = 1'b0;
      #10;
      chk("rst_data", rx_data, 32'd0);
      chk("rst_valid", {31'b0, rx_valid}, 32'd0);
      chk("rst_overrun", {31'b0, overrun}, 32'd0);
      chk("rst_ferr", {31'b0, frame_err}, 32'd0);
      align();
      rst = 1'b0;
      repeat (4) align();

      // 1: single word, consumer always ready
      rx_ready = 1'b1; acc0 = acc_cnt; ferr0 = ferr_cnt;
      exp_q.push_back(32'h6d73e55f);
      cs_on(); send_bits(32'h6d73e55f, 32, 1'b0); cs_off();
      drain();
      chk("t1_accepts", acc_cnt - acc0, 32'd1);
      chk("t1_overrun", {31'b0, overrun}, 32'd0);
      chk("t1_ferr", ferr_cnt - ferr0, 32'd0);

      // 2: three words streamed under one cs
      acc0 = acc_cnt;
      exp_q.push_back(32'h43a53f82); exp_q.push_back(32'hb11924e1); exp_q.push_back(32'h00000001);
      cs_on();
      send_bits(32'h43a53f82, 32, 1'b0);
      send_bits(32'hb11924e1, 32, 1'b0);
      send_bits(32'h00000001, 32, 1'b0);
      cs_off();
      drain();
      chk("t2_accepts", acc_cnt - acc0, 32'd3);
      chk("t2_ferr", ferr_cnt - ferr0, 32'd0);

      // 3: stalled consumer, second word is dropped and overrun sticks
      rx_ready = 1'b0; acc0 = acc_cnt;
      exp_q.push_back(32'h43a53f82);
      cs_on();
      send_bits(32'h43a53f82, 32, 1'b0);
      send_bits(32'hb11924e1, 32, 1'b0);
      cs_off();
      chk("t3_data", rx_data, 32'h43a53f82);
      chk("t3_valid", {31'b0, rx_valid}, 32'd1);
      chk("t3_overrun", {31'b0, overrun}, 32'd1);
      align(); clr_err = 1'b1; align(); clr_err = 1'b0;
      chk("t3_overrun_clr", {31'b0, overrun}, 32'd0);
      drain();
      chk("t3_accepts", acc_cnt - acc0, 32'd1);

      // 4: 13-bit partial frame, then a clean frame
      acc0 = acc_cnt; ferr0 = ferr_cnt;
      cs_on(); send_bits(32'habcd0000, 13, 1'b0); cs_off();
      chk("t4_ferr", ferr_cnt - ferr0, 32'd1);
      chk("t4_no_accept", acc_cnt - acc0, 32'd0);
      chk("t4_valid", {31'b0, rx_valid}, 32'd0);
      exp_q.push_back(32'h6d73e55f);
      cs_on(); send_bits(32'h6d73e55f, 32, 1'b0); cs_off();
      drain();
      chk("t4_accepts", acc_cnt - acc0, 32'd1);
      chk("t4_ferr_after", ferr_cnt - ferr0, 32'd1);

      // 5: accept coincides with completion of the next word
      rx_ready = 1'b0; acc0 = acc_cnt;
      exp_q.push_back(32'h43a53f82); exp_q.push_back(32'hb11924e1);
      cs_on();
      send_bits(32'h43a53f82, 32, 1'b0);
      valid_dropped = 1'b0;
      send_bits(32'hb11924e1, 32, 1'b1);
      cs_off();
      chk("t5_valid_kept", {31'b0, valid_dropped}, 32'd0);
      chk("t5_data", rx_data, 32'hb11924e1);
      chk("t5_overrun", {31'b0, overrun}, 32'd0);
      chk("t5_first_accept", acc_cnt - acc0, 32'd1);
      drain();

      // 6: reset in the middle of a word
      ferr0 = ferr_cnt; acc0 = acc_cnt;
      cs_on(); send_bits(32'hdeadbeef, 20, 1'b0);
      align();
      rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      #8;
      chk("t6_rst_data", rx_data, 32'd0);
      chk("t6_rst_valid", {31'b0, rx_valid}, 32'd0);
      chk("t6_rst_overrun", {31'b0, overrun}, 32'd0);
      chk("t6_rst_ferr", {31'b0, frame_err}, 32'd0);
      align(); rst = 1'b0;
      repeat (4) align();
      exp_q.push_back(32'h6d73e55f);
      cs_on(); send_bits(32'h6d73e55f, 32, 1'b0); cs_off();
      drain();
      chk("t6_accepts", acc_cnt - acc0, 32'd1);
      chk("t6_ferr", ferr_cnt - ferr0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
